// File: rtl/ifetch.sv
// Instruction fetch stage: one outstanding req/ack read per instruction,
// valid/ready hand-off to decode, next-PC write-back, redirect and fault handling.
module ifetch #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o,
  output logic        setPc_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_err_i,
  output logic [31:0] instr_o,
  output logic [31:0] instrPc_o,
  output logic        instrValid_o,
  input  logic        instrReady_i,
  input  logic        redirect_i,
  input  logic [31:0] redirectPc_i,
  output logic        fault_o,
  output logic [1:0]  faultCause_o
);

  // state | meaning
  // FETCH | request the word at pc_i (or fault on a misaligned PC)
  // VALID | instruction held for decode until instrReady_i
  // FAULT | sticky fault, waits for a redirect
  // DRAIN | finish an abandoned request at its original address, discard result
  typedef enum logic [1:0] {FETCH, VALID, FAULT, DRAIN} state_t;

  localparam logic [15:0] CNT_LAST = 16'(BUS_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  cause, cause_nxt;
  logic [31:0] addr_q;
  logic        req, set_pc, load_instr, expire;

  assign expire       = req && !mem_ack_i && (cnt == CNT_LAST);
  assign mem_req_o    = req && !rst_i;
  assign setPc_o      = set_pc && !rst_i;
  assign instrValid_o = (state == VALID);
  assign fault_o      = (state == FAULT);
  assign faultCause_o = cause;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cause_nxt  = cause;
    load_instr = 1'b0;
    req        = 1'b0;
    set_pc     = 1'b0;
    pc_o       = pc_i + 32'd4;
    mem_addr_o = pc_i;
    case (state)
      FETCH: begin
        if (pc_i[1:0] != 2'b00) begin
          state_nxt = FAULT;
          cause_nxt = 2'b01;
        end else begin
          req = 1'b1;
          if (mem_ack_i) begin
            cnt_nxt = '0;
            if (mem_err_i) begin
              state_nxt = FAULT;
              cause_nxt = 2'b10;
            end else begin
              set_pc     = 1'b1;
              load_instr = 1'b1;
              state_nxt  = VALID;
            end
          end else if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = FAULT;
            cause_nxt = 2'b11;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      VALID: if (instrReady_i) state_nxt = FETCH;
      FAULT: ;
      DRAIN: begin
        req        = 1'b1;
        mem_addr_o = addr_q;
        if (mem_ack_i || cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = FETCH;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = FETCH;
    endcase

    // Redirect wins over everything; only a still-live request needs draining.
    if (redirect_i) begin
      set_pc     = 1'b1;
      pc_o       = redirectPc_i;
      cause_nxt  = 2'b00;
      load_instr = 1'b0;
      if (req && !mem_ack_i && !expire) begin
        state_nxt = DRAIN;
      end else begin
        state_nxt = FETCH;
        cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= FETCH;
      cnt       <= '0;
      cause     <= 2'b00;
      addr_q    <= '0;
      instr_o   <= '0;
      instrPc_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cause <= cause_nxt;
      if (state == FETCH) addr_q <= pc_i;
      if (load_instr) begin
        instr_o   <= mem_data_i;
        instrPc_o <= pc_i;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed cycle table, reset corner cases, then random
// bus/decode/redirect traffic checked against a flag-based reference model.
module tb_ifetch;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, pc_o, mem_addr, mem_data, instr, instr_pc, redirect_pc;
  logic        set_pc, mem_req, mem_ack, mem_err, instr_valid, instr_ready, redirect;
  logic        fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  ifetch #(.BUS_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc_i), .pc_o(pc_o), .setPc_o(set_pc),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
    .mem_data_i(mem_data), .mem_err_i(mem_err), .instr_o(instr),
    .instrPc_o(instr_pc), .instrValid_o(instr_valid), .instrReady_i(instr_ready),
    .redirect_i(redirect), .redirectPc_i(redirect_pc), .fault_o(fault),
    .faultCause_o(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc; logic ack; logic err; logic [31:0] data;
    logic rdy; logic rdr; logic [31:0] rpc;
    logic req; logic [31:0] addr; logic set; logic [31:0] pco;
    logic vld; logic [31:0] ins; logic [31:0] ipc; logic flt; logic [1:0] cause;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic [31:0] pc, input logic ack, input logic err,
                             input logic [31:0] data, input logic rdy, input logic rdr,
                             input logic [31:0] rpc, input logic req, input logic [31:0] addr,
                             input logic set, input logic [31:0] pco, input logic vld,
                             input logic [31:0] ins, input logic [31:0] ipc,
                             input logic flt, input logic [1:0] cause);
    vec_t r;
    r.pc = pc; r.ack = ack; r.err = err; r.data = data; r.rdy = rdy; r.rdr = rdr;
    r.rpc = rpc; r.req = req; r.addr = addr; r.set = set; r.pco = pco; r.vld = vld;
    r.ins = ins; r.ipc = ipc; r.flt = flt; r.cause = cause;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic ack, input logic err,
                       input logic [31:0] data, input logic rdy, input logic rdr,
                       input logic [31:0] rpc);
    pc_i = pc; mem_ack = ack; mem_err = err; mem_data = data;
    instr_ready = rdy; redirect = rdr; redirect_pc = rpc;
  endtask

  // reference model state
  bit          m_hold, m_fault, m_drain;
  logic [1:0]  m_cause;
  int          m_age;
  logic [31:0] m_daddr, m_ins, m_ipc, pc_reg;

  localparam logic [31:0] D0 = 32'h0050_0093, D1 = 32'h1111_1111,
                          D2 = 32'h2222_2222, D3 = 32'h3333_3333;

  initial begin
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    vt.push_back(v(32'h0,   0,0,32'h0,      1,0,32'h0,   1,32'h0,  0,32'h0,   0,32'h0,32'h0,  0,2'd0));
    vt.push_back(v(32'h0,   1,0,D0,         1,0,32'h0,   1,32'h0,  1,32'h4,   0,32'h0,32'h0,  0,2'd0));
    for (int i = 0; i < 5; i++)
      vt.push_back(v(32'h4, 0,0,32'h0,      0,0,32'h0,   0,32'h0,  0,32'h0,   1,D0,32'h0,     0,2'd0));
    vt.push_back(v(32'h4,   0,0,32'h0,      1,0,32'h0,   0,32'h0,  0,32'h0,   1,D0,32'h0,     0,2'd0));
    vt.push_back(v(32'h4,   0,0,32'h0,      0,0,32'h0,   1,32'h4,  0,32'h0,   0,D0,32'h0,     0,2'd0));
    vt.push_back(v(32'h4,   1,0,D1,         0,0,32'h0,   1,32'h4,  1,32'h8,   0,D0,32'h0,     0,2'd0));
    vt.push_back(v(32'h8,   0,0,32'h0,      1,0,32'h0,   0,32'h0,  0,32'h0,   1,D1,32'h4,     0,2'd0));
    vt.push_back(v(32'h8,   0,0,32'h0,      0,1,32'h100, 1,32'h8,  1,32'h100, 0,D1,32'h4,     0,2'd0));
    vt.push_back(v(32'h100, 0,0,32'h0,      0,0,32'h0,   1,32'h8,  0,32'h0,   0,D1,32'h4,     0,2'd0));
    vt.push_back(v(32'h100, 1,0,32'hDEADBEEF,0,0,32'h0,  1,32'h8,  0,32'h0,   0,D1,32'h4,     0,2'd0));
    vt.push_back(v(32'h100, 1,0,D2,         0,0,32'h0,   1,32'h100,1,32'h104, 0,D1,32'h4,     0,2'd0));
    vt.push_back(v(32'h104, 0,0,32'h0,      1,0,32'h0,   0,32'h0,  0,32'h0,   1,D2,32'h100,   0,2'd0));
    vt.push_back(v(32'h6,   0,0,32'h0,      0,0,32'h0,   0,32'h0,  0,32'h0,   0,D2,32'h100,   0,2'd0));
    vt.push_back(v(32'h6,   0,0,32'h0,      0,0,32'h0,   0,32'h0,  0,32'h0,   0,D2,32'h100,   1,2'd1));
    vt.push_back(v(32'h6,   0,0,32'h0,      0,1,32'h200, 0,32'h0,  1,32'h200, 0,D2,32'h100,   1,2'd1));
    vt.push_back(v(32'h200, 0,0,32'h0,      0,0,32'h0,   1,32'h200,0,32'h0,   0,D2,32'h100,   0,2'd0));
    vt.push_back(v(32'h200, 1,1,32'h0,      0,0,32'h0,   1,32'h200,0,32'h0,   0,D2,32'h100,   0,2'd0));
    vt.push_back(v(32'h200, 0,0,32'h0,      0,0,32'h0,   0,32'h0,  0,32'h0,   0,D2,32'h100,   1,2'd2));
    vt.push_back(v(32'h200, 0,0,32'h0,      0,1,32'hFFFFFFFC, 0,32'h0, 1,32'hFFFFFFFC, 0,D2,32'h100, 1,2'd2));
    vt.push_back(v(32'hFFFFFFFC, 1,0,D3,    0,0,32'h0,   1,32'hFFFFFFFC, 1,32'h0, 0,D2,32'h100, 0,2'd0));
    vt.push_back(v(32'h0,   0,0,32'h0,      0,0,32'h0,   0,32'h0,  0,32'h0,   1,D3,32'hFFFFFFFC, 0,2'd0));
    vt.push_back(v(32'h0,   0,0,32'h0,      1,1,32'h40,  0,32'h0,  1,32'h40,  1,D3,32'hFFFFFFFC, 0,2'd0));
    for (int i = 0; i < 4; i++)
      vt.push_back(v(32'h40, 0,0,32'h0,     0,0,32'h0,   1,32'h40, 0,32'h0,   0,D3,32'hFFFFFFFC, 0,2'd0));
    vt.push_back(v(32'h40,  0,0,32'h0,      0,0,32'h0,   0,32'h0,  0,32'h0,   0,D3,32'hFFFFFFFC, 1,2'd3));
    vt.push_back(v(32'h40,  0,0,32'h0,      0,1,32'h0,   0,32'h0,  1,32'h0,   0,D3,32'hFFFFFFFC, 1,2'd3));

    repeat (3) @(negedge clk);
    chk("reset_valid", {31'b0, instr_valid}, 32'h0);
    chk("reset_req", {31'b0, mem_req}, 32'h0);
    chk("reset_fault", {29'b0, fault, fault_cause}, 32'h0);
    chk("reset_instr", instr, 32'h0);
    rst = 1'b0;

    // directed cycle table
    foreach (vt[i]) begin
      drive(vt[i].pc, vt[i].ack, vt[i].err, vt[i].data, vt[i].rdy, vt[i].rdr, vt[i].rpc);
      #1;
      chk($sformatf("tbl%0d_req", i), {31'b0, mem_req}, {31'b0, vt[i].req});
      if (vt[i].req) chk($sformatf("tbl%0d_addr", i), mem_addr, vt[i].addr);
      chk($sformatf("tbl%0d_setpc", i), {31'b0, set_pc}, {31'b0, vt[i].set});
      if (vt[i].set) chk($sformatf("tbl%0d_pc", i), pc_o, vt[i].pco);
      chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, vt[i].vld});
      chk($sformatf("tbl%0d_instr", i), instr, vt[i].ins);
      chk($sformatf("tbl%0d_ipc", i), instr_pc, vt[i].ipc);
      chk($sformatf("tbl%0d_fault", i), {31'b0, fault}, {31'b0, vt[i].flt});
      chk($sformatf("tbl%0d_cause", i), {30'b0, fault_cause}, {30'b0, vt[i].cause});
      @(negedge clk);
    end

    // reset asserted mid-request, with a redirect pending
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    #1;
    chk("midrst_req_before", {31'b0, mem_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'b0, mem_req}, 32'h0);
    chk("midrst_setpc", {31'b0, set_pc}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h0, 1'b1, 1'b0, D0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(32'h4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("midrst_valid_before", {31'b0, instr_valid}, 32'h1);
    chk("midrst_instr_before", instr, D0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // random traffic against the reference model
    m_hold = 0; m_fault = 0; m_drain = 0; m_cause = 2'd0; m_age = 0;
    m_daddr = '0; m_ins = '0; m_ipc = '0; pc_reg = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        e_req, e_set, ack, err, rdy, rdr, expire, fetching, lead_drain;
      logic [31:0] e_addr, e_pco, data, rpc;
      fetching = !m_hold && !m_fault && !m_drain;
      e_req    = !m_fault && !m_hold && (m_drain || pc_reg[1:0] == 2'b00);
      e_addr   = m_drain ? m_daddr : pc_reg;
      ack      = e_req && ($urandom_range(0, 2) == 0);
      err      = ack && ($urandom_range(0, 9) == 0);
      data     = $urandom;
      rdy      = 1'($urandom_range(0, 1));
      rdr      = ($urandom_range(0, 11) == 0);
      rpc      = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) rpc = rpc | 32'h2;
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
      expire   = e_req && !ack && (m_age == int'(TMO) - 1);
      e_set    = rdr || (fetching && e_req && ack && !err);
      e_pco    = rdr ? rpc : pc_reg + 32'd4;

      drive(pc_reg, ack, err, data, rdy, rdr, rpc);
      #1;
      chk("rnd_req", {31'b0, mem_req}, {31'b0, e_req});
      if (e_req) chk("rnd_addr", mem_addr, e_addr);
      chk("rnd_setpc", {31'b0, set_pc}, {31'b0, e_set});
      if (e_set) chk("rnd_pc", pc_o, e_pco);
      chk("rnd_valid", {31'b0, instr_valid}, {31'b0, m_hold});
      chk("rnd_instr", instr, m_ins);
      chk("rnd_ipc", instr_pc, m_ipc);
      chk("rnd_fault", {31'b0, fault}, {31'b0, m_fault});
      chk("rnd_cause", {30'b0, fault_cause}, {30'b0, m_cause});

      if (rdr) begin
        lead_drain = e_req && !ack && !expire;
        m_hold = 0; m_fault = 0; m_cause = 2'd0;
        if (lead_drain) begin
          m_daddr = e_addr;
          m_age   = m_age + 1;
        end else begin
          m_age = 0;
        end
        m_drain = lead_drain;
      end else if (fetching) begin
        if (pc_reg[1:0] != 2'b00) begin
          m_fault = 1; m_cause = 2'd1;
        end else if (ack) begin
          m_age = 0;
          if (err) begin
            m_fault = 1; m_cause = 2'd2;
          end else begin
            m_hold = 1; m_ins = data; m_ipc = pc_reg;
          end
        end else if (expire) begin
          m_age = 0; m_fault = 1; m_cause = 2'd3;
        end else begin
          m_age = m_age + 1;
        end
      end else if (m_hold) begin
        if (rdy) m_hold = 0;
      end else if (m_drain) begin
        if (ack || expire) begin
          m_drain = 0; m_age = 0;
        end else begin
          m_age = m_age + 1;
        end
      end
      if (e_set) pc_reg = e_pco;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
